// File: rtl/writeback_demux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | writeback_demux : routes buffered write-back results to the rop register     |
// |                   or to a handshaked GPR write port, in strict FIFO order.   |
// | Optional: define WB_ROP_BYPASS_EN to let rop writes skip an empty FIFO.      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module writeback_demux #(
  parameter int DATA_W = 32,
  parameter int ROP_W  = 12,
  parameter int IDX_W  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_sel,
  input  logic [IDX_W-1:0]         in_idx,
  output logic                     gpr_we,
  output logic [IDX_W-1:0]         gpr_idx,
  output logic [DATA_W-1:0]        gpr_data,
  input  logic                     gpr_ack,
  output logic [ROP_W-1:0]         rop_q,
  output logic                     rop_load,
  output logic                     trunc_ovf,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int                 c_ptr_w = $clog2(DEPTH);
  localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_WAIT_ACK = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [DATA_W-1:0]     r_fifo_data [DEPTH];
  logic [IDX_W-1:0]      r_fifo_idx  [DEPTH];
  logic [DEPTH-1:0]      r_fifo_sel;
  logic [c_ptr_w-1:0]    r_wr_ptr;
  logic [c_ptr_w-1:0]    r_rd_ptr;
  logic [c_ptr_w:0]      r_count;

  logic                  r_gpr_we;
  logic [IDX_W-1:0]      r_gpr_idx;
  logic [DATA_W-1:0]     r_gpr_data;
  logic [ROP_W-1:0]      r_rop_q;
  logic                  r_rop_load;
  logic                  r_trunc_ovf;

  logic                  w_accept;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_rop_upd;
  logic                  w_gpr_start;
  logic [DATA_W-1:0]     w_rop_src;
  logic [DATA_W-1:0]     w_head_data;
  logic [IDX_W-1:0]      w_head_idx;
  logic                  w_head_sel;

  // Ready depends on registered occupancy only, so a pop never frees a slot early.
  assign in_ready = (r_count != c_depth);
  assign w_accept = in_valid && in_ready;

`ifdef WB_ROP_BYPASS_EN
  assign w_bypass = w_accept && !in_sel && (r_count == '0) && (r_state == ST_IDLE);
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push      = w_accept && !w_bypass;
  assign w_head_data = r_fifo_data[r_rd_ptr];
  assign w_head_idx  = r_fifo_idx[r_rd_ptr];
  assign w_head_sel  = r_fifo_sel[r_rd_ptr];

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_rop_upd   = 1'b0;
    w_gpr_start = 1'b0;
    w_rop_src   = w_head_data;
    case (r_state)
      ST_IDLE: begin
        if (r_count != '0) begin
          if (!w_head_sel) begin
            w_pop     = 1'b1;
            w_rop_upd = 1'b1;
          end else if (w_head_idx != '0) begin
            w_gpr_start = 1'b1;
            w_state_nxt = ST_WAIT_ACK;
          end else begin
            // R0 is hardwired zero: drop the write silently.
            w_pop = 1'b1;
          end
        end
      end
      ST_WAIT_ACK: begin
        if (gpr_ack) begin
          w_pop       = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Bypass only fires with an empty FIFO, so it never collides with a head pop.
    if (w_bypass) begin
      w_rop_upd = 1'b1;
      w_rop_src = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= in_data;
      r_fifo_idx[r_wr_ptr]  <= in_idx;
      r_fifo_sel[r_wr_ptr]  <= in_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_gpr_we    <= 1'b0;
      r_gpr_idx   <= '0;
      r_gpr_data  <= '0;
      r_rop_q     <= '0;
      r_rop_load  <= 1'b0;
      r_trunc_ovf <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rop_load <= w_rop_upd;
      if (w_rop_upd) begin
        r_rop_q <= w_rop_src[ROP_W-1:0];
        if (|w_rop_src[DATA_W-1:ROP_W]) r_trunc_ovf <= 1'b1;
      end
      if (w_gpr_start) begin
        r_gpr_we   <= 1'b1;
        r_gpr_idx  <= w_head_idx;
        r_gpr_data <= w_head_data;
      end else if ((r_state == ST_WAIT_ACK) && gpr_ack) begin
        r_gpr_we <= 1'b0;
      end
    end
  end

  assign gpr_we    = r_gpr_we;
  assign gpr_idx   = r_gpr_idx;
  assign gpr_data  = r_gpr_data;
  assign rop_q     = r_rop_q;
  assign rop_load  = r_rop_load;
  assign trunc_ovf = r_trunc_ovf;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_writeback_demux.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_writeback_demux : randomized and directed bench for writeback_demux       |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
module tb_writeback_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_sel;
  logic [3:0]  in_idx;
  logic        gpr_we;
  logic [3:0]  gpr_idx;
  logic [31:0] gpr_data;
  logic        gpr_ack;
  logic [11:0] rop_q;
  logic        rop_load;
  logic        trunc_ovf;
  logic [2:0]  count;

  int n_vec = 0;
  int n_err = 0;

`ifdef WB_ROP_BYPASS_EN
  localparam int ROP_LAT = 0;
`else
  localparam int ROP_LAT = 1;
`endif

  typedef struct {
    logic        sel;
    logic [3:0]  idx;
    logic [31:0] data;
  } ent_t;

  ent_t model_q[$];

  writeback_demux dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_idx(in_idx),
    .gpr_we(gpr_we), .gpr_idx(gpr_idx), .gpr_data(gpr_data), .gpr_ack(gpr_ack),
    .rop_q(rop_q), .rop_load(rop_load), .trunc_ovf(trunc_ovf), .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic push(input logic sel, input logic [3:0] idx, input logic [31:0] data);
    in_valid = 1'b1; in_sel = sel; in_idx = idx; in_data = data;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (rop_q !== 12'h000) begin n_err++; $display("FAIL reset_rop_q: got %h expected 000", rop_q); end
    n_vec++; if (gpr_we !== 1'b0) begin n_err++; $display("FAIL reset_gpr_we: got %b expected 0", gpr_we); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_vec++; if (trunc_ovf !== 1'b0) begin n_err++; $display("FAIL reset_trunc: got %b expected 0", trunc_ovf); end
    n_vec++; if ({gpr_idx, gpr_data, rop_load} !== 37'd0) begin n_err++;
      $display("FAIL reset_gpr_regs: got idx %h data %h load %b expected zeros", gpr_idx, gpr_data, rop_load); end
  endtask

  task automatic test_rop_write();
    push(1'b0, 4'd0, 32'h0000_0FFF);
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (rop_q !== ((k >= ROP_LAT) ? 12'hFFF : 12'h000)) begin n_err++;
        $display("FAIL rop_latency_k%0d: got %h expected %h", k, rop_q, (k >= ROP_LAT) ? 12'hFFF : 12'h000); end
      n_vec++; if (rop_load !== (k == ROP_LAT)) begin n_err++;
        $display("FAIL rop_load_k%0d: got %b expected %b", k, rop_load, k == ROP_LAT); end
      tick();
    end
    n_vec++; if (trunc_ovf !== 1'b0) begin n_err++; $display("FAIL rop_clean_trunc: got %b expected 0", trunc_ovf); end
  endtask

  task automatic test_trunc();
    push(1'b0, 4'd0, 32'hFFFF_FFFF);
    tick(); tick();
    n_vec++; if (rop_q !== 12'hFFF) begin n_err++; $display("FAIL trunc_rop_q: got %h expected FFF", rop_q); end
    n_vec++; if (trunc_ovf !== 1'b1) begin n_err++; $display("FAIL trunc_set: got %b expected 1", trunc_ovf); end
    push(1'b0, 4'd0, 32'h0000_0123);
    tick(); tick();
    n_vec++; if (rop_q !== 12'h123) begin n_err++; $display("FAIL trunc_clean_rop_q: got %h expected 123", rop_q); end
    n_vec++; if (trunc_ovf !== 1'b1) begin n_err++; $display("FAIL trunc_sticky: got %b expected 1", trunc_ovf); end
  endtask

  task automatic test_gpr_wait();
    gpr_ack = 1'b0;
    push(1'b1, 4'd5, 32'hDEAD_BEEF);
    for (int t = 0; t < 5 && !gpr_we; t++) tick();
    n_vec++; if (gpr_we !== 1'b1) begin n_err++; $display("FAIL gpr_we_timeout: got %b expected 1", gpr_we); end
    for (int i = 0; i < 4; i++) begin
      n_vec++; if ({gpr_we, gpr_idx, gpr_data} !== {1'b1, 4'd5, 32'hDEAD_BEEF}) begin n_err++;
        $display("FAIL gpr_hold_%0d: got we %b idx %h data %h expected 1 5 deadbeef", i, gpr_we, gpr_idx, gpr_data); end
      n_vec++; if (count !== 3'd1) begin n_err++; $display("FAIL gpr_hold_count_%0d: got %0d expected 1", i, count); end
      if (i == 3) gpr_ack = 1'b1;
      tick();
    end
    gpr_ack = 1'b0;
    n_vec++; if ({gpr_we, count} !== 4'b0_000) begin n_err++;
      $display("FAIL gpr_after_ack: got we %b count %0d expected 0 0", gpr_we, count); end
  endtask

  task automatic test_full();
    ent_t exp_q[$];
    ent_t e;
    logic        pop_seen;
    logic [3:0]  cap_idx;
    logic [31:0] cap_data;
    gpr_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.sel = 1'b1; e.idx = 4'(i + 1); e.data = $urandom;
      exp_q.push_back(e);
      push(e.sel, e.idx, e.data);
    end
    n_vec++; if ({count, in_ready} !== {3'd4, 1'b0}) begin n_err++;
      $display("FAIL full_state: got count %0d ready %b expected 4 0", count, in_ready); end
    push(1'b1, 4'd9, 32'h5555_AAAA);
    n_vec++; if (count !== 3'd4) begin n_err++; $display("FAIL full_5th_rejected: got count %0d expected 4", count); end
    gpr_ack = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() > 0; t++) begin
      pop_seen = gpr_we && gpr_ack; cap_idx = gpr_idx; cap_data = gpr_data;
      tick();
      if (pop_seen) begin
        e = exp_q.pop_front();
        n_vec++; if ({cap_idx, cap_data} !== {e.idx, e.data}) begin n_err++;
          $display("FAIL full_drain_order: got idx %h data %h expected idx %h data %h", cap_idx, cap_data, e.idx, e.data); end
      end
    end
    gpr_ack = 1'b0;
    n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL full_drain_timeout: got %0d left expected 0", exp_q.size()); end
    n_vec++; if ({in_ready, count} !== {1'b1, 3'd0}) begin n_err++;
      $display("FAIL full_recover: got ready %b count %0d expected 1 0", in_ready, count); end
  endtask

  task automatic test_r0_and_reset();
    logic we_seen = 1'b0;
    gpr_ack = 1'b1;
    push(1'b1, 4'd0, 32'h1234_5678);
    push(1'b0, 4'd0, 32'h0000_0007);
    for (int t = 0; t < 4; t++) begin
      we_seen |= gpr_we;
      tick();
    end
    n_vec++; if (we_seen !== 1'b0) begin n_err++; $display("FAIL r0_no_write: got we_seen %b expected 0", we_seen); end
    n_vec++; if (rop_q !== 12'h007) begin n_err++; $display("FAIL r0_then_rop: got %h expected 007", rop_q); end
    gpr_ack = 1'b0;
    push(1'b1, 4'd3, 32'hCAFE_F00D);
    push(1'b1, 4'd4, 32'h0BAD_CAFE);
    n_vec++; if (gpr_we !== 1'b1) begin n_err++; $display("FAIL pend_before_rst: got %b expected 1", gpr_we); end
    do_reset();
    n_vec++; if ({gpr_we, count, rop_q} !== {1'b0, 3'd0, 12'h000}) begin n_err++;
      $display("FAIL midop_reset: got we %b count %0d rop %h expected 0 0 000", gpr_we, count, rop_q); end
  endtask

  task automatic test_random();
    ent_t        e;
    logic        pushed, pop_seen, exp_trunc;
    logic [3:0]  cap_idx;
    logic [31:0] cap_data;
    exp_trunc = 1'b0;
    model_q.delete();
    for (int cyc = 0; cyc < 360; cyc++) begin
      if (cyc < 300) begin
        in_valid = ($urandom_range(0, 2) != 0);
        in_sel   = $urandom_range(0, 1) == 1;
        in_idx   = 4'($urandom_range(0, 15));
        in_data  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
        gpr_ack  = ($urandom_range(0, 2) != 0);
      end else begin
        in_valid = 1'b0;
        gpr_ack  = 1'b1;
      end
      pushed   = in_valid && in_ready;
      pop_seen = gpr_we && gpr_ack;
      cap_idx  = gpr_idx;
      cap_data = gpr_data;
      e.sel = in_sel; e.idx = in_idx; e.data = in_data;
      tick();
      if (pushed) begin
        if (!(e.sel && e.idx == 4'd0)) model_q.push_back(e);
        if (!e.sel && e.data[31:12] != 20'd0) exp_trunc = 1'b1;
      end
      if (pop_seen) begin
        n_vec++;
        if (model_q.size() == 0 || !model_q[0].sel || model_q[0].idx !== cap_idx || model_q[0].data !== cap_data) begin
          n_err++; $display("FAIL rand_gpr_write cyc %0d: got idx %h data %h, model queue size %0d", cyc, cap_idx, cap_data, model_q.size());
        end
        if (model_q.size() > 0) void'(model_q.pop_front());
      end
      if (rop_load) begin
        n_vec++;
        if (model_q.size() == 0 || model_q[0].sel || rop_q !== model_q[0].data[11:0]) begin
          n_err++; $display("FAIL rand_rop_write cyc %0d: got %h, model queue size %0d", cyc, rop_q, model_q.size());
        end
        if (model_q.size() > 0) void'(model_q.pop_front());
      end
      n_vec++; if (count > 3'd4) begin n_err++; $display("FAIL rand_count_bound: got %0d expected <=4", count); end
    end
    n_vec++; if (model_q.size() != 0) begin n_err++; $display("FAIL rand_drain: got %0d pending expected 0", model_q.size()); end
    n_vec++; if (count !== 3'd0) begin n_err++; $display("FAIL rand_final_count: got %0d expected 0", count); end
    n_vec++; if (trunc_ovf !== exp_trunc) begin n_err++; $display("FAIL rand_trunc: got %b expected %b", trunc_ovf, exp_trunc); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = 1'b0; in_idx = '0; gpr_ack = 1'b0;
    test_reset();
    test_rop_write();
    test_trunc();
    test_gpr_wait();
    test_full();
    test_r0_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
